// File: rtl/tt_scan_pkg.sv
// Shared types and sizes for the truth-table scanner: FSM states, row count
// and the widths of the row index and settle counter.
package tt_scan_pkg;

    localparam int TT_ROWS  = 8;
    localparam int TT_IDX_W = 3;
    localparam int SETTLE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

endpackage

// File: rtl/truth_table_scanner_if.sv
// Control/result handshake plus the gate-side pins of the scanner.
// slave = scanner, master = whoever requests scans and hosts the gate.
interface truth_table_scanner_if;
    import tt_scan_pkg::*;

    logic                 start;
    logic [TT_ROWS-1:0]   expected;
    logic                 busy;
    logic                 done;
    logic [TT_ROWS-1:0]   table_out;
    logic                 match;
    logic                 dut_in1;
    logic                 dut_in2;
    logic                 dut_in3;
    logic                 dut_out;

    modport slave (
        input  start, expected, dut_out,
        output busy, done, table_out, match, dut_in1, dut_in2, dut_in3
    );

    modport master (
        output start, expected, dut_out,
        input  busy, done, table_out, match, dut_in1, dut_in2, dut_in3
    );

endinterface

// File: rtl/truth_table_scanner_sync2.sv
// Two-flop synchroniser bringing the gate's asynchronous output into clk.
// Both stages reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/truth_table_scanner.sv
// Walks a 3-input gate through its 8 rows, samples the synchronised output
// after a settle delay and checks the assembled signature against a target.
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_scanner_if.slave bus
);

    generate
        if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("truth_table_scanner: SETTLE_CYCLES must be within 2..255");
        end
    endgenerate

    localparam logic [SETTLE_W-1:0] LP_CNT_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TT_IDX_W-1:0] LP_IDX_LAST = TT_IDX_W'(TT_ROWS - 1);

    tt_state_e             r_state;
    logic [TT_IDX_W-1:0]   r_idx;
    logic [SETTLE_W-1:0]   r_cnt;
    logic [TT_ROWS-1:0]    r_exp;
    logic [TT_ROWS-1:0]    r_table;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_match;

    logic                  w_out_sync;
    logic [TT_ROWS-1:0]    w_table_nxt;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.dut_out),
        .o_q   (w_out_sync)
    );

    // Row 000 lands in the MSB so the signature reads like the library's hex names.
    always_comb begin
        w_table_nxt = r_table;
        w_table_nxt[LP_IDX_LAST - r_idx] = w_out_sync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_exp   <= '0;
            r_table <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_match <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_exp   <= bus.expected;
                        r_table <= '0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_match <= 1'b0;
                        r_state <= APPLY;
                    end
                end
                APPLY: begin
                    if (r_cnt == LP_CNT_LAST) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    r_table <= w_table_nxt;
                    // Match is judged on the signature including the bit being written now.
                    if (r_idx == LP_IDX_LAST) begin
                        r_done  <= 1'b1;
                        r_match <= (w_table_nxt == r_exp);
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_cnt   <= '0;
                        r_state <= APPLY;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dut_in1   = r_idx[2];
    assign bus.dut_in2   = r_idx[1];
    assign bus.dut_in3   = r_idx[0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.table_out = r_table;
    assign bus.match     = r_match;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed and randomised scans of two scanners (settle 4 and settle 2)
// driving behavioural gate models, checked against a row-by-row reference.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    truth_table_scanner_if ifa ();
    truth_table_scanner_if ifb ();

    truth_table_scanner #(.SETTLE_CYCLES(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    truth_table_scanner #(.SETTLE_CYCLES(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        start_v [2];
    logic [7:0]  exp_v   [2];
    int          kind_v  [2];
    logic [7:0]  tbl_v   [2];
    logic [1:0]  busy_o, done_o, match_o;
    logic [7:0]  table_o [2];
    logic [2:0]  row_o   [2];
    int          done_cnt [2];

    // Gate kinds: 0 = library 0x22 (in2 & ~in3), 1 = buffer of in1, 2 = tie-high,
    // otherwise an arbitrary gate given by its hex name.
    function automatic logic gate_fn(input int kind, input logic [7:0] tbl,
                                     input logic a, input logic b, input logic c);
        int idx;
        idx = 7 - int'({a, b, c});
        case (kind)
            0:       return b & ~c;
            1:       return a;
            2:       return 1'b1;
            default: return tbl[idx];
        endcase
    endfunction

    function automatic logic [7:0] model_table(input int kind, input logic [7:0] tbl);
        logic [7:0] t;
        t = '0;
        for (int r = 0; r < 8; r++) begin
            t[7 - r] = gate_fn(kind, tbl, r[2], r[1], r[0]);
        end
        return t;
    endfunction

    assign ifa.start    = start_v[0];
    assign ifb.start    = start_v[1];
    assign ifa.expected = exp_v[0];
    assign ifb.expected = exp_v[1];
    assign ifa.dut_out  = gate_fn(kind_v[0], tbl_v[0], ifa.dut_in1, ifa.dut_in2, ifa.dut_in3);
    assign ifb.dut_out  = gate_fn(kind_v[1], tbl_v[1], ifb.dut_in1, ifb.dut_in2, ifb.dut_in3);

    assign busy_o     = {ifb.busy, ifa.busy};
    assign done_o     = {ifb.done, ifa.done};
    assign match_o    = {ifb.match, ifa.match};
    assign table_o[0] = ifa.table_out;
    assign table_o[1] = ifb.table_out;
    assign row_o[0]   = {ifa.dut_in1, ifa.dut_in2, ifa.dut_in3};
    assign row_o[1]   = {ifb.dut_in1, ifb.dut_in2, ifb.dut_in3};

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
    end

    always @(negedge clk) begin
        if (done_o[0]) done_cnt[0] <= done_cnt[0] + 1;
        if (done_o[1]) done_cnt[1] <= done_cnt[1] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_reset(input int sel, input string tag);
        chk({tag, "_busy"},  32'(busy_o[sel]),  32'd0);
        chk({tag, "_done"},  32'(done_o[sel]),  32'd0);
        chk({tag, "_match"}, 32'(match_o[sel]), 32'd0);
        chk({tag, "_table"}, 32'(table_o[sel]), 32'h00);
        chk({tag, "_row"},   32'(row_o[sel]),   32'd0);
    endtask

    // One full scan. poke_n > 0 re-pulses start with a different expected mid-scan.
    task automatic do_scan(input int sel, input int s, input int kind, input logic [7:0] tbl,
                           input logic [7:0] expv, input logic [7:0] want, input int poke_n,
                           input string tag);
        int n;
        int d0;
        bit got;
        kind_v[sel]  = kind;
        tbl_v[sel]   = tbl;
        exp_v[sel]   = expv;
        start_v[sel] = 1'b1;
        d0 = done_cnt[sel];
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        chk({tag, "_busy_on_accept"},  32'(busy_o[sel]),  32'd1);
        chk({tag, "_table_cleared"},   32'(table_o[sel]), 32'h00);
        chk({tag, "_row0"},            32'(row_o[sel]),   32'd0);
        n = 0;
        got = 0;
        while (!got && n < 8 * (s + 1) + 20) begin
            @(posedge clk); #1;
            n++;
            if (n == poke_n) begin
                start_v[sel] = 1'b1;
                exp_v[sel]   = ~expv;
            end else if (n == poke_n + 1) begin
                start_v[sel] = 1'b0;
            end
            if (done_o[sel]) got = 1;
            else if (n < 8 * (s + 1)) chk({tag, "_row_step"}, 32'(row_o[sel]), 32'(n / (s + 1)));
        end
        chk({tag, "_done_latency"}, 32'(n), 32'(8 * (s + 1)));
        chk({tag, "_table"},        32'(table_o[sel]), 32'(want));
        chk({tag, "_match"},        32'(match_o[sel]), 32'(want == expv));
        chk({tag, "_row_hold7"},    32'(row_o[sel]),   32'd7);
        chk({tag, "_busy_in_done"}, 32'(busy_o[sel]),  32'd1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse_end"}, 32'(done_o[sel]),  32'd0);
        chk({tag, "_busy_end"},       32'(busy_o[sel]),  32'd0);
        chk({tag, "_match_held"},     32'(match_o[sel]), 32'(want == expv));
        chk({tag, "_row_after"},      32'(row_o[sel]),   32'd7);
        chk({tag, "_one_done"},       32'(done_cnt[sel] - d0), 32'd1);
    endtask

    initial begin
        logic [7:0] rtbl;
        logic [7:0] rexp;
        int sel;
        int n;
        int d0;
        bit got;

        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            exp_v[i]   = 8'h00;
            kind_v[i]  = 0;
            tbl_v[i]   = 8'h00;
        end

        #3;
        chk_idle_reset(0, "rst_a");
        chk_idle_reset(1, "rst_b");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_idle_reset(0, "post_rst_a");

        do_scan(0, 4, 0, 8'h00, 8'h22, 8'h22, 0, "g22_match");
        do_scan(0, 4, 0, 8'h00, 8'h44, 8'h22, 0, "g22_nomatch");
        do_scan(1, 2, 1, 8'h00, 8'h0F, 8'h0F, 0, "s2_in1");
        do_scan(0, 4, 0, 8'h00, 8'h22, 8'h22, 3 * 5 + 1, "restart_ignored");

        // Reset during row 5 of a settle-4 scan.
        kind_v[0]  = 0;
        exp_v[0]   = 8'h22;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (5 * 5 + 2) @(posedge clk);
        #1;
        chk("mid_rst_row5_before", 32'(row_o[0]), 32'd5);
        d0 = done_cnt[0];
        rst_n = 1'b0;
        #1;
        chk_idle_reset(0, "mid_rst");
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_no_done", 32'(done_cnt[0] - d0), 32'd0);
        chk("mid_rst_stays_idle", 32'(busy_o[0]), 32'd0);
        do_scan(0, 4, 0, 8'h00, 8'h22, 8'h22, 0, "after_rst");

        // start held high: back-to-back scans of a tie-high gate.
        kind_v[0]  = 2;
        exp_v[0]   = 8'hFF;
        start_v[0] = 1'b1;
        n = 0;
        got = 0;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (done_o[0]) got = 1;
        end
        chk("b2b_first_done", 32'(n), 32'd41);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            got = 0;
            while (!got && n < 100) begin
                @(posedge clk); #1;
                n++;
                if (n == 2) begin
                    chk("b2b_table_cleared", 32'(table_o[0]), 32'h00);
                    chk("b2b_busy_again",    32'(busy_o[0]),  32'd1);
                end
                if (done_o[0]) got = 1;
            end
            chk("b2b_period", 32'(n), 32'd42);
            chk("b2b_table",  32'(table_o[0]), 32'hFF);
            chk("b2b_match",  32'(match_o[0]), 32'd1);
        end
        start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_stop_idle", 32'(busy_o[0]), 32'd0);

        // Random gates with random or matching targets on either scanner.
        for (int it = 0; it < 8; it++) begin
            sel  = int'($urandom_range(0, 1));
            rtbl = 8'($urandom);
            rexp = ($urandom_range(0, 1) == 1) ? rtbl : 8'($urandom);
            do_scan(sel, (sel == 0) ? 4 : 2, 3, rtbl, rexp, model_table(3, rtbl), 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential characterisation stage wrapped around one 3-input combinational gate of the logic library (e.g. module `0x22`). It sits upstream of the gate and drives `in1`/`in2`/`in3` through all 8 rows. It also sits downstream of the gate: it waits a programmable settle time per row, samples `out` through a synchroniser, and assembles the 8-bit truth-table signature. The signature uses the library's hex naming convention. At the end of a scan it compares the signature against an expected value.

## Interface
- `SETTLE_CYCLES`, default 4: cycles each row is held before sampling. Legal range 2..255; elaboration error outside that range.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: scan request, sampled in IDLE only.
- `expected` input 8: expected signature, latched on the cycle `start` is accepted.
- `dut_in1`, `dut_in2`, `dut_in3` output 1 each: drive the gate's `in1`, `in2`, `in3`.
- `dut_out` input 1: the gate's `out`; asynchronous to `clk`.
- `busy` output 1: high from the cycle after `start` is accepted until DONE is exited.
- `done` output 1: one-cycle pulse at scan end.
- `table_out` output 8: captured signature.
- `match` output 1: `table_out == expected`; valid while `done` is high and held until the next accepted `start`.

## Operation
- States: IDLE, APPLY, SAMPLE, DONE.
- Reset values: state IDLE; row index 0; `dut_in*` 000; `busy` 0; `done` 0; `table_out` 0x00; `match` 0; synchroniser flops 0.
- IDLE, `start`=1:
  - latch `expected`;
  - clear `table_out` to 0x00;
  - row index := 0, so `{dut_in1,dut_in2,dut_in3}` = 3'b000;
  - settle counter := 0;
  - go to APPLY.
- APPLY:
  - counter increments each cycle;
  - when counter == `SETTLE_CYCLES`-1, go to SAMPLE.
- SAMPLE:
  - write the synchronised `dut_out` into `table_out[7-index]`; row 000 is the MSB, so 0x22 means rows 010 and 110 are high;
  - if index == 7, go to DONE;
  - otherwise index+1, drive the new row, clear the counter and go to APPLY.
- DONE:
  - `done`=1 for one cycle;
  - register `match` = (`table_out` incl. final bit == latched expected);
  - return to IDLE.
  - `dut_in*` hold row 111 until the next scan.
- `dut_out` passes through a 2-flop synchroniser before sampling. `SETTLE_CYCLES` ≥ 2 guarantees the sampled value reflects the current row.
- `start` outside IDLE is ignored, with no queuing. `start` held high re-triggers a new scan on the IDLE cycle after DONE.
- `expected` changes after acceptance have no effect.
- Reset asserted mid-scan aborts immediately:
  - all outputs return to reset values;
  - no `done` pulse;
  - partial signature discarded.

## Timing
- `start` accepted at edge k.
- Row r is driven from edge k+r·(S+1), S=`SETTLE_CYCLES`.
- Sample of row r at edge k+r·(S+1)+S+1; the row occupies S APPLY cycles plus 1 SAMPLE cycle.
- DONE state (`done`=1, `match` valid) in the cycle after edge k+8·(S+1).
- Back in IDLE one cycle later.
- Total scan: 8·(S+1)+1 cycles, start to IDLE.
- `busy` = (state != IDLE).
- `table_out` is updated bit-by-bit during the scan; consumers use it only when `done`=1.

## Structure
- Shared package `tt_scan_pkg`:
  - state enum (IDLE/APPLY/SAMPLE/DONE);
  - `TT_ROWS`=8;
  - `TT_IDX_W`=3;
  - `SETTLE_W`=8.
- Sub-module `sync2`: 2-flop synchroniser with async active-low reset to 0; instantiated once on `dut_out`.
- Counter width `SETTLE_W`; index width `TT_IDX_W`; the index never wraps inside a scan.

## Test plan
- Behavioural 0x22 gate model (out = in2 & ~in3), `expected`=0x22, S=4 → `table_out`=0x22, `match`=1, `done` 41 cycles after start acceptance.
- Same gate, `expected`=0x44 → `table_out`=0x22, `match`=0, single `done` pulse.
- S=2, gate out = in1 → `table_out`=0x0F, `match` valid 25 cycles after acceptance; `dut_in*` step 000→111 every 3 cycles.
- `start` pulsed again at row 3 and `expected` changed mid-scan → scan unaffected, one `done` only, result compared against the originally latched value.
- `rst_n` low during row 5 → same-cycle return to `busy`=0, `table_out`=0x00, `dut_in*`=000, no `done`. Next `start` completes normally.
- `start` held high continuously, constant-1 gate → back-to-back scans of 0xFF, `done` every 42 cycles, `table_out` cleared to 0x00 at each start.
